shared_divider: RTL

- Iterative unsigned radix-2 restoring divider with a two-client arbiter. It sits directly downstream of the average-speed stage (client 0) and of a second arithmetic consumer (client 1).
- Produces quotient and remainder, with busy, ready and select status that clients use to sequence requests.
- One divide at a time, one quotient bit per clock.

---
 rtl/shared_divider.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shared_divider.sv
// Two-client iterative restoring divider: round-robin arbitration in IDLE,
// then one quotient bit per clock, with a single-cycle shortcut for zero divisors.
module shared_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             req1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic             busy,
    output logic             ready,
    output logic             select,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any_req;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_dvd;
    logic [WIDTH-1:0] w_sel_dsr;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req1;
        end
        w_sel_dvd = w_grant ? dividend1 : dividend0;
        w_sel_dsr = w_grant ? divisor1 : divisor0;
    end

    // The partial remainder stays below the divisor, so the WIDTH+1 bit trial's
    // MSB is its sign; r_dvd shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        w_shift    = {r_rem, r_dvd[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_dsr};
        w_q_bit    = ~w_trial[WIDTH];
        w_rem_next = w_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_dvd_next = {r_dvd[WIDTH-2:0], w_q_bit};
    end

    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_rem        <= '0;
            r_dvd        <= '0;
            r_dsr        <= '0;
            r_cnt        <= '0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            select       <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        select       <= w_grant;
                        r_last_grant <= w_grant;
                        busy         <= 1'b1;
                        div_by_zero  <= 1'b0;
                        r_dvd        <= w_sel_dvd;
                        r_dsr        <= w_sel_dsr;
                        r_rem        <= '0;
                        r_cnt        <= CNT_W'(WIDTH);
                        r_state      <= (w_sel_dsr == '0) ? S_DONE : S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        quotient  <= w_dvd_next;
                        remainder <= w_rem_next;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_DONE: begin
                    quotient    <= '1;
                    remainder   <= r_dvd;
                    div_by_zero <= 1'b1;
                    busy        <= 1'b0;
                    ready       <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
